// File: rtl/int_ctrl_if.sv
// -----------------------------------------------------------------------------
// int_ctrl_if -- bus bundle between the interrupt controller and the core.
//
// Groups the configuration write port and the request/acknowledge handshake.
//   cfg_we     configuration write strobe, single cycle (core -> ctrl)
//   cfg_addr   0 = enable, 1 = mode (1 = edge), 2 = pending W1C, 3 = reserved
//   cfg_wdata  configuration write data, N_CH bits (core -> ctrl)
//   int_ask    interrupt request (ctrl -> core)
//   int_num    8-bit vector number of the request (ctrl -> core)
//   int_ack    acknowledge from the core's interrupt unit (core -> ctrl)
//
// Modports:
//   master  the interrupt controller (originates int_ask/int_num)
//   slave   the core side (drives configuration and int_ack)
// -----------------------------------------------------------------------------
interface int_ctrl_if #(
  parameter int N_CH = 16
);
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [N_CH-1:0] cfg_wdata;
  logic            int_ask;
  logic [7:0]      int_num;
  logic            int_ack;

  modport master (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack,
    output int_ask, int_num
  );

  modport slave (
    output cfg_we, cfg_addr, cfg_wdata, int_ack,
    input  int_ask, int_num
  );
endinterface

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl -- N_CH-channel interrupt controller with a two-state request FSM.
//
// Each channel is either edge-triggered (pending set on a rising edge of src,
// cleared by ack or W1C) or level-sensitive (pending follows src). Eligible
// channels (pending & enabled) are dispatched one at a time: int_ask/int_num
// are held from the cycle after selection until int_ack.
//
// Parameters:
//   N_CH      number of source channels, 1..256
//   VEC_BASE  vector number of channel 0; int_num = (VEC_BASE + cur) mod 256
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   src       raw source lines, synchronous to clk
//   glb_en    global dispatch enable
//   bus       int_ctrl_if.master: configuration port and request handshake
//   pending   current pending bits
//   en_q      enable register readback
//   mode_q    mode register readback (1 = edge, 0 = level)
//
// Build option:
//   INT_CTRL_RR_EN  when defined, selection is round-robin starting after the
//                   last served channel; otherwise lowest eligible index wins.
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int          N_CH     = 16,
  parameter logic [7:0]  VEC_BASE = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] src,
  input  logic            glb_en,
  int_ctrl_if.master      bus,
  output logic [N_CH-1:0] pending,
  output logic [N_CH-1:0] en_q,
  output logic [N_CH-1:0] mode_q
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE, ASK} state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] src_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] eligible, rise, w1c_mask, ack_mask;
  logic [IW-1:0]   cur_q, sel;
  logic [7:0]      num_q, sel_num;
  logic            grant, ack_take;

  assign eligible = pend_q & en_q;
  assign rise     = src & ~src_q;
  assign grant    = (state_q == IDLE) && glb_en && (|eligible);
  assign ack_take = (state_q == ASK) && bus.int_ack;
  assign pending  = pend_q;

  // ---------------------------------------------------------------------------
  // Channel selection
  // ---------------------------------------------------------------------------
`ifdef INT_CTRL_RR_EN
  logic [IW-1:0] last_q;

  // Scan offsets high-to-low so the smallest offset from last_served+1 wins.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    idx = 0;
    sel = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (eligible[IW'(idx)]) sel = IW'(idx);
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest eligible index.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) sel = IW'(i);
    end
  end
`endif

  // Zero-extend the index to 8 bits; the add wraps modulo 256.
  always_comb begin
    sel_num         = '0;
    sel_num[IW-1:0] = sel;
    sel_num         = VEC_BASE + sel_num;
  end

  // ---------------------------------------------------------------------------
  // Pending update
  // ---------------------------------------------------------------------------
  always_comb begin
    w1c_mask = '0;
    if (bus.cfg_we && bus.cfg_addr == 2'd2) w1c_mask = bus.cfg_wdata;
    ack_mask = '0;
    if (ack_take) ack_mask[cur_q] = 1'b1;
    // Edge channels: a new edge overrides a same-cycle clear.
    // Level channels: follow src, untouched by ack and W1C.
    pend_d = (mode_q & (rise | (pend_q & ~(ack_mask | w1c_mask))))
           | (~mode_q & src);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)       state_d = ASK;
      ASK:     if (bus.int_ack) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // FSM: outputs. int_num comes from a register loaded on grant so it is
  // stable for the whole request regardless of later pending/enable changes.
  always_comb begin
    bus.int_ask = (state_q == ASK);
    bus.int_num = num_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath and configuration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_q  <= '0;
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      cur_q  <= '0;
      num_q  <= '0;
    end else begin
      src_q  <= src;
      pend_q <= pend_d;
      if (bus.cfg_we && bus.cfg_addr == 2'd0) en_q   <= bus.cfg_wdata;
      if (bus.cfg_we && bus.cfg_addr == 2'd1) mode_q <= bus.cfg_wdata;
      if (grant) begin
        cur_q <= sel;
        num_q <= sel_num;
      end
    end
  end

`ifdef INT_CTRL_RR_EN
  // Start the first search at channel 0.
  always_ff @(posedge clk) begin
    if (!rst_n)        last_q <= IW'(N_CH - 1);
    else if (ack_take) last_q <= cur_q;
  end
`endif

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl -- directed, table-driven bench for int_ctrl (N_CH=16,
// VEC_BASE=0x20). Each table row gives the inputs for one clock and the
// outputs expected right after that edge; hand-written sequences follow for
// the selection-order and glb_en cases.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam int N_CH = 16;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] src;
  logic            glb_en;
  logic [N_CH-1:0] pending, en_q, mode_q;

  int_ctrl_if #(.N_CH(N_CH)) bus ();

  int_ctrl #(.N_CH(N_CH), .VEC_BASE(8'h20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .src     (src),
    .glb_en  (glb_en),
    .bus     (bus),
    .pending (pending),
    .en_q    (en_q),
    .mode_q  (mode_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic [15:0] src;
    logic        glb_en;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        ack;
    logic        exp_ask;
    logic [7:0]  exp_num;
    logic [15:0] exp_pend;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t v(input string name, input logic r, input logic [15:0] s,
                             input logic g, input logic we, input logic [1:0] a,
                             input logic [15:0] wd, input logic ack, input logic ea,
                             input logic [7:0] en, input logic [15:0] ep);
    vec_t t;
    t.name = name; t.rst_n = r; t.src = s; t.glb_en = g; t.we = we;
    t.addr = a; t.wdata = wd; t.ack = ack; t.exp_ask = ea; t.exp_num = en;
    t.exp_pend = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [15:0] s, input logic g,
                        input logic we, input logic [1:0] a, input logic [15:0] wd,
                        input logic ack);
    rst_n = r; src = s; glb_en = g;
    bus.cfg_we = we; bus.cfg_addr = a; bus.cfg_wdata = wd; bus.int_ack = ack;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  exp_d, exp_f;
    logic [15:0] exp_e;

    set_in(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, 1'b0);

    //               name         rst src      glb we addr wdata    ack ask num    pend
    vecs.push_back(v("reset",     0, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0000));
    vecs.push_back(v("wr_en",     1, 16'h0000, 0, 1, 2'd0, 16'hFFFF, 0, 0, 8'h00, 16'h0000));
    vecs.push_back(v("wr_mode",   1, 16'h0000, 0, 1, 2'd1, 16'hFFFF, 0, 0, 8'h00, 16'h0000));
    vecs.push_back(v("idle",      1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0000));
    // Single edge on channel 5: pending at t+1, request at t+2.
    vecs.push_back(v("c5_edge",   1, 16'h0020, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0020));
    vecs.push_back(v("c5_ask",    1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h25, 16'h0020));
    vecs.push_back(v("c5_hold",   1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h25, 16'h0020));
    vecs.push_back(v("c5_ack",    1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0000));
    vecs.push_back(v("c5_done",   1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0000));
    vecs.push_back(v("ack_idle",  1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0000));
    // Channels 3 and 9 together: lower index first, one idle cycle between.
    vecs.push_back(v("c39_edge",  1, 16'h0208, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0208));
    vecs.push_back(v("c3_ask",    1, 16'h0208, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h23, 16'h0208));
    vecs.push_back(v("c3_ack",    1, 16'h0208, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0200));
    vecs.push_back(v("c9_ask",    1, 16'h0208, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h29, 16'h0200));
    vecs.push_back(v("c9_ack",    1, 16'h0208, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0000));
    vecs.push_back(v("c39_drop",  1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0000));
    // Request on 7 held while en and glb_en drop.
    vecs.push_back(v("c7_edge",   1, 16'h0080, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0080));
    vecs.push_back(v("c7_en0",    1, 16'h0000, 1, 1, 2'd0, 16'h0000, 0, 1, 8'h27, 16'h0080));
    vecs.push_back(v("c7_glb0",   1, 16'h0000, 0, 0, 2'd0, 16'h0000, 0, 1, 8'h27, 16'h0080));
    vecs.push_back(v("c7_ack",    1, 16'h0000, 0, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0000));
    // Pending 7 while masked; enabling it requests two cycles after the write.
    vecs.push_back(v("c7_mask",   1, 16'h0080, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0080));
    vecs.push_back(v("c7_noask1", 1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0080));
    vecs.push_back(v("c7_noask2", 1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0080));
    vecs.push_back(v("c7_wr_en",  1, 16'h0000, 1, 1, 2'd0, 16'h0080, 0, 0, 8'h00, 16'h0080));
    vecs.push_back(v("c7_ask2",   1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h27, 16'h0080));
    vecs.push_back(v("c7_ack2",   1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0000));
    // W1C, then W1C colliding with a new edge (set wins), then reserved write.
    vecs.push_back(v("c0_edge",   1, 16'h0001, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0001));
    vecs.push_back(v("w1c",       1, 16'h0000, 1, 1, 2'd2, 16'h0001, 0, 0, 8'h00, 16'h0000));
    vecs.push_back(v("w1c_set",   1, 16'h0001, 1, 1, 2'd2, 16'h0001, 0, 0, 8'h00, 16'h0001));
    vecs.push_back(v("wr_rsvd",   1, 16'h0000, 1, 1, 2'd3, 16'hFFFF, 0, 0, 8'h00, 16'h0001));
    // Level channel 2 held across ack.
    vecs.push_back(v("c2_en",     1, 16'h0000, 1, 1, 2'd0, 16'h0004, 0, 0, 8'h00, 16'h0001));
    vecs.push_back(v("c2_level",  1, 16'h0000, 1, 1, 2'd1, 16'hFFFB, 0, 0, 8'h00, 16'h0001));
    vecs.push_back(v("c2_hi",     1, 16'h0004, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0005));
    vecs.push_back(v("c2_ask",    1, 16'h0004, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h22, 16'h0005));
    vecs.push_back(v("c2_ack",    1, 16'h0004, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0005));
    vecs.push_back(v("c2_ask_b",  1, 16'h0004, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h22, 16'h0005));
    vecs.push_back(v("c2_ack_b",  1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0001));
    vecs.push_back(v("c2_quiet1", 1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0001));
    vecs.push_back(v("c2_quiet2", 1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0001));
    // Level -> edge keeps the pending bit.
    vecs.push_back(v("c2_hi2",    1, 16'h0004, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0005));
    vecs.push_back(v("c2_to_edge",1, 16'h0004, 1, 1, 2'd1, 16'hFFFF, 0, 1, 8'h22, 16'h0005));
    vecs.push_back(v("c2_kept",   1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h22, 16'h0005));
    vecs.push_back(v("c2_ack_e",  1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1, 0, 8'h00, 16'h0001));
    // Edge -> level on channel 0 applies the cycle after the write.
    vecs.push_back(v("c0_to_lvl", 1, 16'h0000, 1, 1, 2'd1, 16'hFFFE, 0, 0, 8'h00, 16'h0001));
    vecs.push_back(v("c0_lvl",    1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0000));
    // Reset during ASK.
    vecs.push_back(v("c2_edge3",  1, 16'h0004, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0004));
    vecs.push_back(v("c2_ask3",   1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 1, 8'h22, 16'h0004));
    vecs.push_back(v("rst_ask",   0, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0000));
    vecs.push_back(v("post_rst1", 1, 16'h0004, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0004));
    vecs.push_back(v("post_rst2", 1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0, 0, 8'h00, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].rst_n, vecs[i].src, vecs[i].glb_en, vecs[i].we,
             vecs[i].addr, vecs[i].wdata, vecs[i].ack);
      step();
      check({vecs[i].name, " ask"},  32'(bus.int_ask), 32'(vecs[i].exp_ask));
      check({vecs[i].name, " pend"}, 32'(pending),     32'(vecs[i].exp_pend));
      // int_num is only defined while asking, and is zero after reset.
      if (vecs[i].exp_ask || !vecs[i].rst_n)
        check({vecs[i].name, " num"}, 32'(bus.int_num), 32'(vecs[i].exp_num));
      if (!vecs[i].rst_n) begin
        check({vecs[i].name, " en_q"},   32'(en_q),   32'h0);
        check({vecs[i].name, " mode_q"}, 32'(mode_q), 32'h0);
      end
    end

    // Selection order with channels 1 and 4 re-triggering.
`ifdef INT_CTRL_RR_EN
    exp_d = 8'h24; exp_e = 16'h0002; exp_f = 8'h21;
`else
    exp_d = 8'h21; exp_e = 16'h0010; exp_f = 8'h24;
`endif
    set_in(1, 16'h0000, 1, 1, 2'd0, 16'hFFFF, 0); step();
    set_in(1, 16'h0000, 1, 1, 2'd1, 16'hFFFF, 0); step();
    check("rb en_q",   32'(en_q),   32'h0000FFFF);
    check("rb mode_q", 32'(mode_q), 32'h0000FFFF);
    set_in(1, 16'h0012, 1, 0, 2'd0, 16'h0000, 0); step();
    check("sel pend0", 32'(pending), 32'h0012);
    set_in(1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0); step();
    check("sel ask1", 32'(bus.int_ask), 32'h1);
    check("sel num1", 32'(bus.int_num), 32'h21);
    set_in(1, 16'h0002, 1, 0, 2'd0, 16'h0000, 1); step();
    check("sel ack1 ask", 32'(bus.int_ask), 32'h0);
    check("sel ack1 pend", 32'(pending), 32'h0012);
    set_in(1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0); step();
    check("sel ask2", 32'(bus.int_ask), 32'h1);
    check("sel num2", 32'(bus.int_num), 32'(exp_d));
    set_in(1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1); step();
    check("sel ack2 pend", 32'(pending), 32'(exp_e));
    set_in(1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0); step();
    check("sel ask3", 32'(bus.int_ask), 32'h1);
    check("sel num3", 32'(bus.int_num), 32'(exp_f));
    set_in(1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1); step();
    check("sel ack3 pend", 32'(pending), 32'h0);

    // glb_en=0 holds off dispatch; raising it requests on the next edge.
    set_in(1, 16'h0008, 0, 0, 2'd0, 16'h0000, 0); step();
    check("glb pend", 32'(pending), 32'h0008);
    set_in(1, 16'h0000, 0, 0, 2'd0, 16'h0000, 0); step();
    check("glb off1", 32'(bus.int_ask), 32'h0);
    step();
    check("glb off2", 32'(bus.int_ask), 32'h0);
    set_in(1, 16'h0000, 1, 0, 2'd0, 16'h0000, 0); step();
    check("glb on ask", 32'(bus.int_ask), 32'h1);
    check("glb on num", 32'(bus.int_num), 32'h23);
    set_in(1, 16'h0000, 1, 0, 2'd0, 16'h0000, 1); step();
    check("glb ack", 32'(bus.int_ask), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_CH, default 16, number of interrupt source channels, legal range 1..256.
REQ-002 Parameter VEC_BASE, default 0, 8-bit vector number assigned to channel 0.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 src  input  N_CH  raw interrupt source lines, already synchronous to clk.
REQ-006 glb_en  input  1  global dispatch enable (1 = dispatch allowed).
REQ-007 cfg_we  input  1  configuration write strobe, single cycle.
REQ-008 cfg_addr  input  2  0 = enable register, 1 = mode register (1 = edge, 0 = level), 2 = pending W1C, 3 = reserved (write ignored).
REQ-009 cfg_wdata  input  N_CH  configuration write data.
REQ-010 int_ack  input  1  acknowledge from the core's interrupt unit.
REQ-011 int_ask  output  1  interrupt request to the core.
REQ-012 int_num  output  8  vector number for the request.
REQ-013 pending  output  N_CH  current pending bits.
REQ-014 en_q / mode_q  output  N_CH each  current enable and mode registers (readback).

Function
REQ-015 Edge channel: a rising edge on src[i] (src[i]=1 with previous-cycle sample 0) SHALL set pending[i] on the next clock.
REQ-016 Level channel: pending[i] SHALL be loaded with src[i] every cycle; neither ack nor W1C affects it.
REQ-017 Edge channel: pending[i] SHALL clear on ack of channel i or on a W1C write with cfg_wdata[i]=1; if set and clear occur in the same cycle, set SHALL win.
REQ-018 eligible[i] = pending[i] & en_q[i]; writes to en_q and mode_q SHALL take effect the cycle after cfg_we.
REQ-019 The FSM SHALL have two states: IDLE and ASK.
REQ-020 IDLE: if glb_en=1 and any eligible bit is set, latch the selected index into cur, drive int_ask=1 and int_num=(VEC_BASE+cur) mod 256 from the next cycle, then go to ASK; otherwise stay in IDLE with int_ask=0.
REQ-021 ASK: int_ask and int_num SHALL stay stable until int_ack=1; masking, deasserting glb_en or deasserting src SHALL NOT retract the request.
REQ-022 ASK with int_ack=1: clear pending[cur] if cur is an edge channel; go to IDLE; drive int_ask=0 on the next cycle.
REQ-023 Back-to-back requests SHALL be separated by exactly one cycle with int_ask=0.
REQ-024 int_ack in IDLE SHALL be ignored.
REQ-025 Latency SHALL be 2 cycles. An edge sampled at cycle t sets pending at t+1 and drives int_ask=1 at t+2, provided the controller is in IDLE and the channel is enabled.
REQ-026 Default selection SHALL use fixed priority: the lowest eligible index wins.
REQ-027 Mode change edge to level SHALL take effect the cycle after the write; level to edge SHALL keep the current pending bit.

Reset
REQ-028 With rst_n=0 at a clock edge, all of the following SHALL be 0 on the next cycle: int_ask, int_num, pending, en_q, mode_q, the src history and cur; the FSM SHALL be in IDLE.
REQ-029 Reset during ASK SHALL drop int_ask the cycle after; no ack is required.
REQ-030 Under INT_CTRL_RR_EN, reset SHALL set last_served to N_CH-1.

Configuration
REQ-031 With macro INT_CTRL_RR_EN defined, selection SHALL be round-robin. The search starts at (last_served+1) mod N_CH and wraps. last_served updates to cur on each ack.
REQ-032 With INT_CTRL_RR_EN undefined, selection SHALL be fixed priority per REQ-026 and no last_served register SHALL exist.

Verification
REQ-033 Setup: N_CH=16, VEC_BASE=0x20, en=0xFFFF, all channels edge. Pulse src[5] at t -> pending[5] at t+1; int_ask=1 with int_num=0x25 at t+2; after int_ack, int_ask=0 and pending[5]=0.
REQ-034 Same setup; raise src[3] and src[9] in the same cycle -> first int_num=0x23 and pending[9] stays 1. After ack, one cycle with int_ask=0, then int_num=0x29.
REQ-035 Level channel 2 with src[2] held high across ack -> a second request with int_num=0x22 follows after the one idle cycle. Drop src[2] -> no further request.
REQ-036 During ASK, write en=0 and glb_en=0 -> int_ask and int_num unchanged until ack. Pending[7] edge-set with en[7]=0 -> no request; write en[7]=1 -> int_ask=1 two cycles after the write.
REQ-037 Assert rst_n=0 during ASK -> next cycle int_ask=0 and pending=0. Under INT_CTRL_RR_EN, keep src[1] and src[4] continuously re-triggering -> grants alternate 0x21, 0x24, 0x21.
